// File: rtl/ioctl_region_loader.sv
// Host ioctl download loader: maps a download index onto a memory region,
// optionally byte-swaps, buffers words in a FWFT FIFO and issues req/ack writes.
module ioctl_region_loader #(
  parameter int                    DW          = 16,
  parameter int                    AW          = 25,
  parameter int                    DEPTH       = 4,
  parameter int                    NREGION     = 4,
  parameter logic [NREGION*AW-1:0] REGION_BASE = {NREGION{AW'(0)}},
  parameter logic [NREGION-1:0]    REGION_SWAP = NREGION'(1)
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [DW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic [23:0]   words,
  output logic          err_unmapped,
  output logic          err_overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] WAIT_CNT = (PW+1)'(DEPTH - 1);
  localparam logic [6:0]  NREG7    = 7'(NREGION);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          dl_q, dl_d;
  logic [5:0]    region_q, region_d;
  logic          mapped_q, mapped_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [AW-1:0] addr_mem_d [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [DW-1:0] data_mem_d [DEPTH];
  logic [23:0]   words_q, words_d;
  logic          done_q, done_d;
  logic          wait_q, wait_d;
  logic          busy_q, busy_d;
  logic          err_unmapped_q, err_unmapped_d;
  logic          err_overflow_q, err_overflow_d;

  logic          rise, fall, pop, push, wr_ok, full, start, idx_mapped, swap_sel;
  logic [AW-1:0] base;
  logic [DW-1:0] dout_swapped;
  logic          unused_idx_hi;

  assign unused_idx_hi = ^ioctl_index[7:6];

  always_comb begin
    state_d        = state_q;
    dl_d           = ioctl_download;
    region_d       = region_q;
    mapped_d       = mapped_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    addr_mem_d     = addr_mem_q;
    data_mem_d     = data_mem_q;
    words_d        = words_q;
    done_d         = 1'b0;
    err_unmapped_d = err_unmapped_q;
    err_overflow_d = err_overflow_q;
    start          = 1'b0;

    rise       = ioctl_download && !dl_q;
    fall       = !ioctl_download && dl_q;
    idx_mapped = {1'b0, ioctl_index[5:0]} < NREG7;
    full       = (count_q == FULL_CNT);
    pop        = (count_q != '0) && mem_ack;
    wr_ok      = (state_q == LOAD) && ioctl_wr && mapped_q;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push       = wr_ok && (!full || pop);
    if (wr_ok && full && !pop) err_overflow_d = 1'b1;

    base     = '0;
    swap_sel = 1'b0;
    for (int i = 0; i < NREGION; i++) begin
      if (region_q == 6'(i)) begin
        base     = REGION_BASE[i*AW +: AW];
        swap_sel = REGION_SWAP[i];
      end
    end
    dout_swapped = ioctl_dout;
    for (int b = 0; b < DW/8; b++) dout_swapped[b*8 +: 8] = ioctl_dout[(DW/8-1-b)*8 +: 8];

    if (push) begin
      addr_mem_d[wr_ptr_q] = base + AW'(ioctl_addr);
      data_mem_d[wr_ptr_q] = swap_sel ? dout_swapped : ioctl_dout;
      wr_ptr_d             = wr_ptr_q + 1'b1;
      words_d              = words_q + 24'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    case (state_q)
      IDLE:  if (rise) start = 1'b1;
      LOAD:  if (fall) state_d = DRAIN;
      DRAIN: begin
        // Completion is judged on the post-pop occupancy so done follows the last ack by one cycle.
        if (count_d == '0) begin
          done_d = 1'b1;
          if (ioctl_download) start = 1'b1;
          else                state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d  = LOAD;
      region_d = ioctl_index[5:0];
      mapped_d = idx_mapped;
      words_d  = '0;
      if (!idx_mapped) err_unmapped_d = 1'b1;
    end

    wait_d = (state_d == DRAIN) || (count_d >= WAIT_CNT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      dl_q           <= 1'b0;
      region_q       <= '0;
      mapped_q       <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      words_q        <= '0;
      done_q         <= 1'b0;
      wait_q         <= 1'b0;
      busy_q         <= 1'b0;
      err_unmapped_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dl_q           <= dl_d;
      region_q       <= region_d;
      mapped_q       <= mapped_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      addr_mem_q     <= addr_mem_d;
      data_mem_q     <= data_mem_d;
      words_q        <= words_d;
      done_q         <= done_d;
      wait_q         <= wait_d;
      busy_q         <= busy_d;
      err_unmapped_q <= err_unmapped_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign ioctl_wait   = wait_q;
  assign mem_req      = (count_q != '0);
  assign mem_addr     = addr_mem_q[rd_ptr_q];
  assign mem_din      = data_mem_q[rd_ptr_q];
  assign busy         = busy_q;
  assign done         = done_q;
  assign words        = words_q;
  assign err_unmapped = err_unmapped_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ioctl_region_loader.sv
// Directed bench for ioctl_region_loader: region mapping, swap, wrap, throttling,
// overflow, unmapped index, drain-to-reload and asynchronous reset.
module tb_ioctl_region_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic [23:0] words;
  logic        err_unmapped;
  logic        err_overflow;

  int total = 0;
  int bad   = 0;

  logic [24:0] exp_a_q[$];
  logic [15:0] exp_q[$];

  always #5 clk_sys = ~clk_sys;

  ioctl_region_loader #(
    .DW(16), .AW(25), .DEPTH(4), .NREGION(4),
    .REGION_BASE({25'h0, 25'h1FF_FFFE, 25'h000_1000, 25'h0}),
    .REGION_SWAP(4'b0011)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_ack(mem_ack), .busy(busy), .done(done),
    .words(words), .err_unmapped(err_unmapped), .err_overflow(err_overflow)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; mem_ack = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    tick();
  endtask

  task automatic host_write(input logic [24:0] a, input logic [15:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl;
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    total++; if ({ioctl_wait, mem_req, busy, done, err_unmapped, err_overflow} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
        {ioctl_wait, mem_req, busy, done, err_unmapped, err_overflow});
    end
    total++; if (mem_addr !== 25'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    total++; if (mem_din !== 16'h0) begin bad++; $display("FAIL reset_din: got %h want 0", mem_din); end
    total++; if (words !== 24'd0) begin bad++; $display("FAIL reset_words: got %0d want 0", words); end
  endtask

  task automatic test_region0_swap;
    logic [24:0] a_tab [3];
    logic [15:0] d_tab [3];
    logic [15:0] e_tab [3];
    a_tab = '{25'h0, 25'h2, 25'h4};
    d_tab = '{16'h1234, 16'h5678, 16'h9ABC};
    e_tab = '{16'h3412, 16'h7856, 16'hBC9A};
    start_dl(8'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL r0_busy: got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      host_write(a_tab[i], d_tab[i]);
      total++; if ({mem_req, mem_addr, mem_din} !== {1'b1, a_tab[i], e_tab[i]}) begin
        bad++; $display("FAIL r0_write%0d: got req=%b addr=%h din=%h want req=1 addr=%h din=%h",
          i, mem_req, mem_addr, mem_din, a_tab[i], e_tab[i]);
      end
      tick();
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL r0_pop%0d: got req=%b want 0", i, mem_req); end
    end
    total++; if (words !== 24'd3) begin bad++; $display("FAIL r0_words: got %0d want 3", words); end
    end_dl();
    total++; if ({busy, done, ioctl_wait} !== 3'b101) begin
      bad++; $display("FAIL r0_drain: got busy/done/wait=%b want 101", {busy, done, ioctl_wait});
    end
    tick();
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL r0_done: got busy/done=%b want 01", {busy, done}); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL r0_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_wrap;
    start_dl(8'd2);
    host_write(25'h0, 16'hA55A);
    host_write(25'h2, 16'h0FF0);
    total++; if ({mem_req, mem_addr, mem_din} !== {1'b1, 25'h1FF_FFFE, 16'hA55A}) begin
      bad++; $display("FAIL wrap_first: got req=%b addr=%h din=%h want 1 1fffffe a55a", mem_req, mem_addr, mem_din);
    end
    mem_ack = 1'b1; tick();
    total++; if ({mem_req, mem_addr, mem_din} !== {1'b1, 25'h0, 16'h0FF0}) begin
      bad++; $display("FAIL wrap_second: got req=%b addr=%h din=%h want 1 0000000 0ff0", mem_req, mem_addr, mem_din);
    end
    tick(); mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wrap_empty: got req=%b want 0", mem_req); end
    end_dl(); tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b want 1", done); end
  endtask

  task automatic test_stall_wait;
    start_dl(8'd1);
    host_write(25'h0, 16'h1122);
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL stall_wait1: got %b want 0", ioctl_wait); end
    host_write(25'h2, 16'h3344);
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL stall_wait2: got %b want 0", ioctl_wait); end
    host_write(25'h4, 16'h5566);
    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL stall_wait3: got %b want 1", ioctl_wait); end
    repeat (20) tick();
    total++; if ({ioctl_wait, mem_req, err_overflow, mem_addr, mem_din} !== {3'b110, 25'h1000, 16'h2211}) begin
      bad++; $display("FAIL stall_hold: got wait/req/ovf=%b addr=%h din=%h want 110 1000 2211",
        {ioctl_wait, mem_req, err_overflow}, mem_addr, mem_din);
    end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", ioctl_wait); end
    host_write(25'h6, 16'h7788);
    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL stall_refill: got %b want 1", ioctl_wait); end
    exp_a_q = '{25'h1002, 25'h1004, 25'h1006};
    exp_q   = '{16'h4433, 16'h6655, 16'h8877};
    end_dl();
    while (exp_q.size() > 0) begin
      logic [24:0] ea;
      logic [15:0] ed;
      ea = exp_a_q.pop_front(); ed = exp_q.pop_front();
      total++; if ({mem_req, mem_addr, mem_din} !== {1'b1, ea, ed}) begin
        bad++; $display("FAIL stall_drain: got req=%b addr=%h din=%h want 1 %h %h", mem_req, mem_addr, mem_din, ea, ed);
      end
      mem_ack = 1'b1; tick();
    end
    mem_ack = 1'b0;
    total++; if ({done, busy, mem_req} !== 3'b100) begin
      bad++; $display("FAIL stall_done: got done/busy/req=%b want 100", {done, busy, mem_req});
    end
    total++; if (words !== 24'd4) begin bad++; $display("FAIL stall_words: got %0d want 4", words); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_full_push_pop;
    start_dl(8'd0);
    for (int i = 0; i < 4; i++) host_write(25'(2*i), 16'h0A01 + 16'(i));
    ioctl_wr = 1'b1; ioctl_addr = 25'h8; ioctl_dout = 16'h0A05; mem_ack = 1'b1;
    tick();
    ioctl_wr = 1'b0; mem_ack = 1'b0;
    total++; if ({err_overflow, ioctl_wait, words} !== {2'b01, 24'd5}) begin
      bad++; $display("FAIL fpp_state: got ovf/wait=%b words=%0d want 01 5", {err_overflow, ioctl_wait}, words);
    end
    exp_a_q = '{25'h2, 25'h4, 25'h6, 25'h8};
    exp_q   = '{16'h020A, 16'h030A, 16'h040A, 16'h050A};
    end_dl();
    while (exp_q.size() > 0) begin
      logic [24:0] ea;
      logic [15:0] ed;
      ea = exp_a_q.pop_front(); ed = exp_q.pop_front();
      total++; if ({mem_req, mem_addr, mem_din} !== {1'b1, ea, ed}) begin
        bad++; $display("FAIL fpp_drain: got req=%b addr=%h din=%h want 1 %h %h", mem_req, mem_addr, mem_din, ea, ed);
      end
      mem_ack = 1'b1; tick();
    end
    mem_ack = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL fpp_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_overflow;
    do_reset();
    start_dl(8'd0);
    for (int i = 0; i < 6; i++) host_write(25'(2*i), 16'h00F0 + 16'(i));
    total++; if ({err_overflow, words} !== {1'b1, 24'd4}) begin
      bad++; $display("FAIL ovf_flag: got ovf=%b words=%0d want 1 4", err_overflow, words);
    end
    exp_a_q = '{25'h0, 25'h2, 25'h4, 25'h6};
    exp_q   = '{16'hF000, 16'hF100, 16'hF200, 16'hF300};
    end_dl();
    while (exp_q.size() > 0) begin
      logic [24:0] ea;
      logic [15:0] ed;
      ea = exp_a_q.pop_front(); ed = exp_q.pop_front();
      total++; if ({mem_req, mem_addr, mem_din} !== {1'b1, ea, ed}) begin
        bad++; $display("FAIL ovf_drain: got req=%b addr=%h din=%h want 1 %h %h", mem_req, mem_addr, mem_din, ea, ed);
      end
      mem_ack = 1'b1; tick();
    end
    mem_ack = 1'b0;
    total++; if ({done, mem_req} !== 2'b10) begin bad++; $display("FAIL ovf_done: got done/req=%b want 10", {done, mem_req}); end
    tick();
  endtask

  task automatic test_unmapped;
    start_dl(8'd7);
    total++; if ({err_unmapped, busy} !== 2'b11) begin
      bad++; $display("FAIL unm_flag: got unm/busy=%b want 11", {err_unmapped, busy});
    end
    host_write(25'h0, 16'h1111);
    host_write(25'h2, 16'h2222);
    total++; if ({mem_req, words} !== {1'b0, 24'd0}) begin
      bad++; $display("FAIL unm_discard: got req=%b words=%0d want 0 0", mem_req, words);
    end
    end_dl();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL unm_early_done: got %b want 0", done); end
    tick();
    total++; if ({done, busy, err_unmapped} !== 3'b101) begin
      bad++; $display("FAIL unm_done: got done/busy/unm=%b want 101", {done, busy, err_unmapped});
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    start_dl(8'd0);
    host_write(25'h0, 16'h1111);
    host_write(25'h2, 16'h2222);
    end_dl();
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    total++; if ({busy, done, mem_addr, mem_din} !== {2'b10, 25'h0, 16'h1111}) begin
      bad++; $display("FAIL b2b_hold: got busy/done=%b addr=%h din=%h want 10 0 1111", {busy, done}, mem_addr, mem_din);
    end
    mem_ack = 1'b1; tick();
    total++; if ({mem_req, mem_addr, mem_din} !== {1'b1, 25'h2, 16'h2222}) begin
      bad++; $display("FAIL b2b_next: got req=%b addr=%h din=%h want 1 2 2222", mem_req, mem_addr, mem_din);
    end
    tick(); mem_ack = 1'b0;
    total++; if ({done, busy, mem_req, ioctl_wait, words} !== {4'b1100, 24'd0}) begin
      bad++; $display("FAIL b2b_reload: got done/busy/req/wait=%b words=%0d want 1100 0",
        {done, busy, mem_req, ioctl_wait}, words);
    end
    host_write(25'h8, 16'hABCD);
    total++; if ({mem_req, mem_addr, mem_din, words} !== {1'b1, 25'h1008, 16'hCDAB, 24'd1}) begin
      bad++; $display("FAIL b2b_region1: got req=%b addr=%h din=%h words=%0d want 1 1008 cdab 1",
        mem_req, mem_addr, mem_din, words);
    end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    end_dl(); tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
  endtask

  task automatic test_reset_midstream;
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) host_write(25'(2*i), 16'hDEA0 + 16'(i));
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_pre: got req=%b want 1", mem_req); end
    reset_n = 1'b0;
    #1;
    total++; if ({mem_req, busy, ioctl_wait, words} !== {3'b000, 24'd0}) begin
      bad++; $display("FAIL rst_async: got req/busy/wait=%b words=%0d want 000 0", {mem_req, busy, ioctl_wait}, words);
    end
    ioctl_download = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    total++; if ({mem_req, busy, done, words} !== {3'b000, 24'd0}) begin
      bad++; $display("FAIL rst_after: got req/busy/done=%b words=%0d want 000 0", {mem_req, busy, done}, words);
    end
  endtask

  initial begin
    test_reset();
    test_region0_swap();
    test_wrap();
    test_stall_wait();
    test_full_push_pop();
    test_overflow();
    test_unmapped();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
